// File: rtl/pcpi_sha_sched.sv
// PCPI coprocessor for the SHA-256 message schedule: keeps a 16-word sliding
// window of W[t] and produces the next schedule word on request.
module pcpi_sha_sched #(
    parameter logic [6:0] OPCODE        = 7'b0001011,
    parameter bit         ABORT_ON_DROP = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_ready,
    output logic        pcpi_wait
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        R0   = 3'd1,
        R1   = 3'd2,
        R2   = 3'd3,
        R3   = 3'd4,
        RESP = 3'd5
    } state_t;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 5'd3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 5'd10);
    endfunction

    state_t      state_r;
    logic [31:0] win_r [16];
    logic [3:0]  wptr_r;
    logic [4:0]  cnt_r;
    logic [31:0] acc_r;

    logic        hit_s;
    logic        is_load_s;
    logic        is_next_s;
    logic        is_clr_s;
    logic        drop_s;
    logic [4:0]  cnt_inc_s;
    logic [31:0] op_s;
    logic [31:0] sum_s;
    logic        win_we_s;
    logic [31:0] win_wdata_s;
    logic        unused_s;

    assign unused_s  = ^{pcpi_rs2, pcpi_insn[31:15], pcpi_insn[11:7]};
    assign hit_s     = pcpi_valid && (pcpi_insn[6:0] == OPCODE);
    assign is_load_s = hit_s && (pcpi_insn[14:12] == 3'b001);
    assign is_next_s = hit_s && (pcpi_insn[14:12] == 3'b010);
    assign is_clr_s  = hit_s && (pcpi_insn[14:12] == 3'b011);
    assign drop_s    = ABORT_ON_DROP && !pcpi_valid;
    assign cnt_inc_s = (cnt_r == 5'd16) ? 5'd16 : (cnt_r + 5'd1);
    assign sum_s     = acc_r + op_s;

    // Operand selection: one window tap per round, indices wrap naturally in 4 bits
    always_comb begin
        op_s = 32'd0;
        case (state_r)
            R0:      op_s = win_r[wptr_r];
            R1:      op_s = sigma0(win_r[wptr_r + 4'd1]);
            R2:      op_s = win_r[wptr_r + 4'd9];
            R3:      op_s = sigma1(win_r[wptr_r + 4'd14]);
            default: op_s = 32'd0;
        endcase
    end

    // Window write port: LOAD stores rs1, a completed NEXT replaces the oldest word
    always_comb begin
        win_we_s    = 1'b0;
        win_wdata_s = pcpi_rs1;
        if (reset) begin
            win_we_s = 1'b0;
        end else if ((state_r == IDLE) && is_load_s) begin
            win_we_s = 1'b1;
        end else if ((state_r == R3) && !drop_s) begin
            win_we_s    = 1'b1;
            win_wdata_s = sum_s;
        end else begin
            win_we_s = 1'b0;
        end
    end

    // Window storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (win_we_s) begin
            win_r[wptr_r] <= win_wdata_s;
        end
    end

    // Control FSM with registered PCPI outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            wptr_r     <= 4'd0;
            cnt_r      <= 5'd0;
            acc_r      <= 32'd0;
            pcpi_wr    <= 1'b0;
            pcpi_rd    <= 32'd0;
            pcpi_ready <= 1'b0;
            pcpi_wait  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    pcpi_wr    <= 1'b0;
                    pcpi_rd    <= 32'd0;
                    pcpi_ready <= 1'b0;
                    pcpi_wait  <= 1'b0;
                    if (is_load_s) begin
                        wptr_r     <= wptr_r + 4'd1;
                        cnt_r      <= cnt_inc_s;
                        pcpi_rd    <= {27'd0, cnt_inc_s};
                        pcpi_wr    <= 1'b1;
                        pcpi_ready <= 1'b1;
                        state_r    <= RESP;
                    end else if (is_clr_s) begin
                        wptr_r     <= 4'd0;
                        cnt_r      <= 5'd0;
                        pcpi_wr    <= 1'b1;
                        pcpi_ready <= 1'b1;
                        state_r    <= RESP;
                    end else if (is_next_s && (cnt_r == 5'd16)) begin
                        pcpi_wait <= 1'b1;
                        state_r   <= R0;
                    end else if (is_next_s) begin
                        // Window not yet full: complete without a write-back
                        pcpi_ready <= 1'b1;
                        state_r    <= RESP;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                R0, R1, R2: begin
                    if (drop_s) begin
                        pcpi_wait <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        acc_r   <= (state_r == R0) ? op_s : sum_s;
                        state_r <= (state_r == R0) ? R1 : ((state_r == R1) ? R2 : R3);
                    end
                end
                R3: begin
                    pcpi_wait <= 1'b0;
                    if (drop_s) begin
                        state_r <= IDLE;
                    end else begin
                        wptr_r     <= wptr_r + 4'd1;
                        pcpi_rd    <= sum_s;
                        pcpi_wr    <= 1'b1;
                        pcpi_ready <= 1'b1;
                        state_r    <= RESP;
                    end
                end
                RESP: begin
                    pcpi_wr    <= 1'b0;
                    pcpi_rd    <= 32'd0;
                    pcpi_ready <= 1'b0;
                    pcpi_wait  <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    pcpi_wr    <= 1'b0;
                    pcpi_rd    <= 32'd0;
                    pcpi_ready <= 1'b0;
                    pcpi_wait  <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcpi_sha_sched.sv
// Scoreboard bench for pcpi_sha_sched: directed SHA-256 "abc" schedule vectors,
// clear/partial-window, unclaimed funct3, drop-abort and mid-operation reset.
module tb_pcpi_sha_sched;

    localparam logic [6:0] OPC     = 7'b0001011;
    localparam logic [2:0] F_SIG0  = 3'b000;
    localparam logic [2:0] F_LOAD  = 3'b001;
    localparam logic [2:0] F_NEXT  = 3'b010;
    localparam logic [2:0] F_CLR   = 3'b011;

    logic        clk = 1'b0;
    logic        reset;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_ready;
    logic        pcpi_wait;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] exp_q [$];
    logic [32:0] mon_e;
    logic [31:0] abc [16];

    pcpi_sha_sched dut (
        .clk        (clk),
        .reset      (reset),
        .pcpi_valid (pcpi_valid),
        .pcpi_insn  (pcpi_insn),
        .pcpi_rs1   (pcpi_rs1),
        .pcpi_rs2   (pcpi_rs2),
        .pcpi_wr    (pcpi_wr),
        .pcpi_rd    (pcpi_rd),
        .pcpi_ready (pcpi_ready),
        .pcpi_wait  (pcpi_wait)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [2:0] f3);
        return {17'd0, f3, 5'd0, OPC};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every completion pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (pcpi_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got ready=1 rd=0x%08h expected no response", pcpi_rd);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_wr", {31'd0, pcpi_wr}, {31'd0, mon_e[32]});
                check("resp_rd", pcpi_rd, mon_e[31:0]);
            end
        end else if ((pcpi_rd !== 32'd0) || (pcpi_wr !== 1'b0)) begin
            checks++;
            errors++;
            $display("FAIL idle_outputs: got wr=%0b rd=0x%08h expected wr=0 rd=0", pcpi_wr, pcpi_rd);
        end
    end

    // Issue one claimed instruction; caller is just after a rising edge
    task automatic issue(input string tag, input logic [2:0] f3, input logic [31:0] rs1,
                         input logic ewr, input logic [31:0] erd, input int elat, input int ewait);
        int  lat;
        int  waits;
        bit  seen;
        lat   = 0;
        waits = 0;
        seen  = 1'b0;
        exp_q.push_back({ewr, erd});
        pcpi_valid = 1'b1;
        pcpi_insn  = mk(f3);
        pcpi_rs1   = rs1;
        @(posedge clk);
        while (!seen && (lat < 20)) begin
            @(negedge clk);
            lat++;
            if (pcpi_wait === 1'b1) waits++;
            if (pcpi_ready === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no ready in 20 cycles expected ready", tag);
        end else begin
            check({tag, "_lat"}, 32'(lat), 32'(elat));
            check({tag, "_wait"}, 32'(waits), 32'(ewait));
        end
        @(posedge clk);
        #1;
        pcpi_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rdy_n;
        int wait_n;
        int wr_n;
        for (int i = 0; i < 16; i++) abc[i] = 32'd0;
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;

        reset      = 1'b1;
        pcpi_valid = 1'b0;
        pcpi_insn  = 32'd0;
        pcpi_rs1   = 32'd0;
        pcpi_rs2   = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, pcpi_ready}, 32'd0);
        check("rst_wait",  {31'd0, pcpi_wait},  32'd0);
        check("rst_wr",    {31'd0, pcpi_wr},    32'd0);
        check("rst_rd",    pcpi_rd,             32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Full "abc" block, first LOAD presented in the first cycle out of reset
        for (int i = 0; i < 16; i++) issue("load_abc", F_LOAD, abc[i], 1'b1, 32'(i + 1), 1, 0);

        issue("next16", F_NEXT, 32'd0, 1'b1, 32'h61626380, 5, 4);
        issue("next17", F_NEXT, 32'd0, 1'b1, 32'h000F0000, 5, 4);
        issue("next18", F_NEXT, 32'd0, 1'b1, 32'h7DA86405, 5, 4);

        // Drop valid during R1: no completion, no state change
        pcpi_valid = 1'b1;
        pcpi_insn  = mk(F_NEXT);
        @(posedge clk);
        @(posedge clk);
        #1;
        pcpi_valid = 1'b0;
        rdy_n  = 0;
        wait_n = 0;
        repeat (8) begin
            @(negedge clk);
            if (pcpi_ready === 1'b1) rdy_n++;
            if (pcpi_wait === 1'b1) wait_n++;
        end
        check("drop_ready", 32'(rdy_n), 32'd0);
        check("drop_wait",  32'(wait_n), 32'd1);
        @(posedge clk);
        #1;
        issue("next19", F_NEXT, 32'd0, 1'b1, 32'h600003C6, 5, 4);

        issue("clr", F_CLR, 32'hFFFFFFFF, 1'b1, 32'd0, 1, 0);
        issue("next_part", F_NEXT, 32'd0, 1'b0, 32'd0, 1, 0);
        issue("load_after_clr", F_LOAD, 32'h11111111, 1'b1, 32'd1, 1, 0);

        // Unclaimed funct3 held for 20 cycles
        pcpi_valid = 1'b1;
        pcpi_insn  = mk(F_SIG0);
        pcpi_rs1   = 32'h12345678;
        rdy_n  = 0;
        wait_n = 0;
        wr_n   = 0;
        repeat (20) begin
            @(negedge clk);
            if (pcpi_ready === 1'b1) rdy_n++;
            if (pcpi_wait === 1'b1) wait_n++;
            if (pcpi_wr === 1'b1) wr_n++;
        end
        check("sig0_ready", 32'(rdy_n), 32'd0);
        check("sig0_wait",  32'(wait_n), 32'd0);
        check("sig0_wr",    32'(wr_n), 32'd0);
        @(posedge clk);
        #1;
        pcpi_valid = 1'b0;
        issue("load_after_sig0", F_LOAD, 32'h22222222, 1'b1, 32'd2, 1, 0);

        // Refill, saturate the count, then NEXT across the overwritten oldest slot
        issue("clr2", F_CLR, 32'd0, 1'b1, 32'd0, 1, 0);
        for (int i = 0; i < 16; i++) issue("reload", F_LOAD, abc[i], 1'b1, 32'(i + 1), 1, 0);
        issue("load_sat", F_LOAD, 32'hCAFEF00D, 1'b1, 32'd16, 1, 0);
        issue("next_wrap", F_NEXT, 32'd0, 1'b1, 32'h000F0000, 5, 4);

        // Reset pulse while the NEXT is in R2
        pcpi_valid = 1'b1;
        pcpi_insn  = mk(F_NEXT);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        issue("load_after_rst", F_LOAD, 32'hDEADBEEF, 1'b1, 32'd1, 1, 0);

        repeat (10) @(posedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pcpi_sha_sched.md
PCPI_SHA_SCHED -- requirements
Module: pcpi_sha_sched

Interface
REQ-001 Parameter: OPCODE, default 7'b0001011, custom-0 major opcode decoded by the block.
REQ-002 Parameter: ABORT_ON_DROP, default 1, abort an in-flight operation when pcpi_valid falls before pcpi_ready.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: pcpi_valid  input  1  CPU presents an instruction; held until pcpi_ready.
REQ-006 Port: pcpi_insn  input  32  instruction word; opcode [6:0], funct3 [14:12].
REQ-007 Port: pcpi_rs1  input  32  source operand.
REQ-008 Port: pcpi_rs2  input  32  unused; ignored.
REQ-009 Port: pcpi_wr  output  1  write rd back; valid only with pcpi_ready.
REQ-010 Port: pcpi_rd  output  32  result word.
REQ-011 Port: pcpi_ready  output  1  one-cycle completion pulse.
REQ-012 Port: pcpi_wait  output  1  high while a claimed operation is in flight.

Function
REQ-013 The block SHALL hold a 16 x 32-bit circular window W[0..15], a 4-bit write pointer wptr and a 5-bit fill count cnt (0..16).
REQ-014 The block SHALL claim only insn[6:0]==OPCODE with funct3 in {001 LOAD, 010 NEXT, 011 CLR}; other funct3 values (000 = Sigma0 unit) SHALL get no response and leave state unchanged.
REQ-015 All outputs SHALL be registered; a new instruction SHALL be accepted only in state IDLE.
REQ-016 FSM states: IDLE, R0, R1, R2, R3, RESP; RESP SHALL last exactly one cycle and then go to IDLE unconditionally.
REQ-017 LOAD: on accept, W[wptr]<=rs1, wptr<=wptr+1 (mod 16), cnt<=min(cnt+1,16); IDLE->RESP; pcpi_rd = updated cnt, pcpi_wr=1, pcpi_ready=1 in the cycle after accept.
REQ-018 CLR: on accept, wptr<=0, cnt<=0; window contents are don't-care; IDLE->RESP; pcpi_rd=0, pcpi_wr=1.
REQ-019 NEXT with cnt<16: IDLE->RESP with pcpi_wr=0, pcpi_rd=0, no state change (CPU keeps old rd).
REQ-020 NEXT with cnt==16: IDLE->R0->R1->R2->R3->RESP, one operand per cycle into a 32-bit accumulator: R0 W[wptr] (t-16), R1 sigma0(W[wptr+1]) (t-15), R2 W[wptr+9] (t-7), R3 sigma1(W[wptr+14]) (t-2), indices mod 16.
REQ-021 sigma0(x)=ROTR7^ROTR18^SHR3; sigma1(x)=ROTR17^ROTR19^SHR10; all additions modulo 2^32, carries discarded.
REQ-022 On R3->RESP the block SHALL write the sum to W[wptr] (overwriting t-16), increment wptr; cnt stays 16; pcpi_rd = sum, pcpi_wr=1.
REQ-023 NEXT latency: pcpi_ready SHALL assert exactly 5 cycles after the accept cycle.
REQ-024 pcpi_wait SHALL be high from the cycle after accept through R3, and low in IDLE and RESP.
REQ-025 pcpi_wait, pcpi_ready and pcpi_wr SHALL be 0 for unclaimed instructions.
REQ-026 With ABORT_ON_DROP=1, pcpi_valid low during R0..R3 SHALL return the FSM to IDLE next cycle with no window, wptr or cnt update and no pcpi_ready.
REQ-027 wptr wrap 15->0 SHALL be seamless for LOAD and NEXT; LOAD at cnt==16 overwrites the oldest word.
REQ-028 pcpi_rd SHALL be 0 whenever pcpi_ready is 0.

Reset
REQ-029 While reset is high at a clock edge: FSM<=IDLE, wptr<=0, cnt<=0, accumulator<=0, pcpi_wr/pcpi_ready/pcpi_wait<=0, pcpi_rd<=0; window RAM not reset.
REQ-030 Reset asserted mid-NEXT SHALL abandon the operation with no write and no pcpi_ready.
REQ-031 After reset deasserts, an instruction presented in the first cycle SHALL be accepted.

Verification
REQ-032 LOAD 16 words of padded "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018) -> rd=1..16, ready 1 cycle after each accept.
REQ-033 Then NEXT x3 -> rd 0x61626380, 0x000F0000, 0x7DA86405; ready 5 cycles after accept; wait high 4 cycles each.
REQ-034 After CLR, NEXT -> ready with wr=0, rd=0; subsequent LOAD -> rd=1.
REQ-035 funct3=000 with OPCODE -> no ready/wait/wr for 20 cycles; cnt unchanged.
REQ-036 Reset pulse during R2 of NEXT, then LOAD 0xDEADBEEF -> no ready from aborted NEXT; LOAD rd=1.
REQ-037 pcpi_valid dropped in R1 -> no ready; a repeated NEXT returns the same value it would have without the drop.
